tick_period_meter: RTL and testbench
====================================

Name: tick_period_meter

Overview:
- Receiver-side counterpart of the board-level reference-clock divider.
- Takes a single-cycle strobe stream, such as a divided reference tick, and measures the clk-cycle spacing between successive strobes, recovering the divide ratio N.
- Reports each measured period over a valid/ready handshake.
- Flags lock once the spacing is stable, and flags overflow and dropped results.
- Used for board bring-up self-check of tick generators and for timer calibration.

Parameters:
- BW, 8: width of the period counter and period output; largest measurable period is 2^BW-1.
- LOCK_CNT, 4: number of consecutive equal periods needed to assert locked (1..15).

Ports:
- clk  input  1  global clock
- rst_n  input  1  global reset
- enable  input  1  measurement enable, level
- tick_in  input  1  strobe input, same clk domain; every high cycle is one event
- clr_flags  input  1  one-cycle pulse; clears sticky overflow and missed
- period  output  BW  last accepted measurement, in clk cycles
- period_valid  output  1  period holds an unconsumed result
- period_ready  input  1  consumer accepts period this cycle
- locked  output  1  spacing stable for LOCK_CNT consecutive measurements
- overflow  output  1  sticky: no event within 2^BW-1 cycles
- missed  output  1  sticky: result discarded because output was still occupied

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. All state updates on posedge clk.
- Reset values: period=0, period_valid=0, locked=0, overflow=0, missed=0; FSM=IDLE; cnt=0; match=0.
- States: IDLE, ARM, MEAS.
- IDLE:
  - enable=1 -> ARM.
  - tick_in is ignored.
- ARM (waiting for the first event):
  - tick_in=1 -> MEAS, cnt<=1.
  - No result is produced on the first event.
- MEAS:
  - On each cycle, cnt holds the cycles elapsed since the last event.
  - tick_in=1: a measurement completes with value cnt. Set cnt<=1 and stay in MEAS.
  - tick_in=0 and cnt<all-ones: cnt<=cnt+1.
  - tick_in=0 and cnt==all-ones: set overflow, locked<=0, match<=0, go to ARM. No result.
  - An event arriving exactly at cnt==all-ones is a valid measurement of 2^BW-1.
- enable=0 in any state:
  - Next state IDLE; cnt<=0, match<=0, locked<=0.
  - A pending period/period_valid is retained until accepted; the handshake is never broken.
- Continuously high tick_in (N=1): every cycle is an event, so the period is 1.
- Output handshake:
  - A completed measurement is registered: period_valid rises the cycle after the event cycle.
  - Slot empty, or period_valid&&period_ready in the same cycle: load period and keep period_valid=1.
  - Slot full and not ready: discard the new measurement and set missed. The held period is unchanged.
  - period_valid&&period_ready with no new measurement: period_valid<=0. period keeps its value.
- Lock logic (evaluated on every completed measurement, including discarded ones):
  - last holds the previous measurement.
  - new==last: match<=min(match+1, LOCK_CNT).
  - new!=last: match<=0, last<=new.
  - locked is registered and equals (match==LOCK_CNT). It asserts the cycle after the completing event.
- clr_flags clears overflow and missed. If a set condition occurs in the same cycle, set wins.
- Width rules: cnt and period are BW bits unsigned; match is 4 bits; no arithmetic wraps.

Decomposition:
- Shared board-common package holds:
  - FSM state encoding (IDLE=2'd0, ARM=2'd1, MEAS=2'd2);
  - a default BW constant shared with the divider.
- One natural sub-module, tick_lock_det:
  - contains last, match and locked;
  - inputs: meas_strobe, meas_value, clear;
  - output: locked.

Test Plan:
- Divider N=2 strobes, enable=1, period_ready=1 -> first result period=2 one cycle after the 2nd strobe; locked=1 after the 6th strobe (LOCK_CNT=4); no flags.
- Strobes at N=5, then spacing changes to 7 -> locked drops the cycle after the first 7-cycle result, then re-asserts after 4 more equal 7s.
- No strobe for 255 cycles after arming (BW=8) -> overflow=1 and FSM returns to ARM. With a strobe at exactly 255 cycles instead -> period=255 and no overflow.
- period_ready=0 with N=3 strobes -> first period=3 is held and missed=1 on the next result. Then ready=1 and clr_flags together with a new event -> new result loads, valid stays 1, missed is cleared.
- tick_in held high continuously -> period=1 every cycle, locked after 5 cycles of results.
- enable deasserted mid-MEAS with an unconsumed result -> locked=0 next cycle; period_valid stays 1 until ready. Re-enable -> first strobe only arms, with no result until the second strobe.

Source files
------------

// File: rtl/tick_period_meter_pkg.sv
// Shared board-common definitions for the tick period meter and the
// reference-clock divider it pairs with.
package tick_period_meter_pkg;

  localparam int unsigned DefaultBw = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StMeas = 2'd2
  } meter_state_e;

endpackage

// File: rtl/tick_lock_det.sv
// Lock detector: asserts locked once LOCK_CNT consecutive measurements equal
// their predecessor; clear drops the run count but keeps the last value.
module tick_lock_det #(
  parameter int unsigned BW       = 8,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          meas_strobe,
  input  logic [BW-1:0] meas_value,
  input  logic          clear,
  output logic          locked
);

  localparam logic [3:0] MatchMax = 4'(LOCK_CNT);

  logic [BW-1:0] last_q, last_d;
  logic [3:0]    match_q, match_d;
  logic          locked_q, locked_d;

  always_comb begin
    last_d   = last_q;
    match_d  = match_q;
    locked_d = locked_q;
    if (clear) begin
      match_d  = 4'd0;
      locked_d = 1'b0;
    end else if (meas_strobe) begin
      if (meas_value == last_q) begin
        if (match_q < MatchMax) begin
          match_d = match_q + 4'd1;
        end
      end else begin
        match_d = 4'd0;
        last_d  = meas_value;
      end
      locked_d = (match_d == MatchMax);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= '0;
      match_q  <= 4'd0;
      locked_q <= 1'b0;
    end else begin
      last_q   <= last_d;
      match_q  <= match_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures clk-cycle spacing between tick_in strobes and reports each period
// over valid/ready, with lock, overflow and dropped-result flags.
module tick_period_meter
  import tick_period_meter_pkg::*;
#(
  parameter int unsigned BW       = DefaultBw,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          tick_in,
  input  logic          clr_flags,
  output logic [BW-1:0] period,
  output logic          period_valid,
  input  logic          period_ready,
  output logic          locked,
  output logic          overflow,
  output logic          missed
);

  localparam logic [BW-1:0] CntOne = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] CntMax = '1;

  meter_state_e  state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] period_q, period_d;
  logic          valid_q, valid_d;
  logic          overflow_q, overflow_d;
  logic          missed_q, missed_d;

  logic meas_strobe;
  logic ovf_evt;
  logic missed_evt;
  logic lock_clear;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    meas_strobe = 1'b0;
    ovf_evt     = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StArm;
        StArm: begin
          if (tick_in) begin
            state_d = StMeas;
            cnt_d   = CntOne;
          end
        end
        StMeas: begin
          if (tick_in) begin
            meas_strobe = 1'b1;
            cnt_d       = CntOne;
          end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntOne;
          end else begin
            // No event within the measurable range: re-arm on the next one.
            ovf_evt = 1'b1;
            state_d = StArm;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    period_d   = period_q;
    valid_d    = valid_q;
    missed_evt = 1'b0;
    if (meas_strobe) begin
      if (!valid_q || period_ready) begin
        period_d = cnt_q;
        valid_d  = 1'b1;
      end else begin
        missed_evt = 1'b1;
      end
    end else if (valid_q && period_ready) begin
      valid_d = 1'b0;
    end
    overflow_d = (overflow_q && !clr_flags) || ovf_evt;
    missed_d   = (missed_q && !clr_flags) || missed_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      missed_q   <= missed_d;
    end
  end

  assign lock_clear = !enable || ovf_evt;

  tick_lock_det #(
    .BW       (BW),
    .LOCK_CNT (LOCK_CNT)
  ) u_lock_det (
    .clk         (clk),
    .rst_n       (rst_n),
    .meas_strobe (meas_strobe),
    .meas_value  (cnt_q),
    .clear       (lock_clear),
    .locked      (locked)
  );

  assign period       = period_q;
  assign period_valid = valid_q;
  assign overflow     = overflow_q;
  assign missed       = missed_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: directed scenarios plus random strobe streams,
// each cycle compared against an event-timestamp reference model.
module tb_tick_period_meter;

  localparam int unsigned BW       = 8;
  localparam int unsigned LOCK_CNT = 4;
  localparam int          MaxCnt   = (1 << BW) - 1;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          tick_in;
  logic          clr_flags;
  logic [BW-1:0] period;
  logic          period_valid;
  logic          period_ready;
  logic          locked;
  logic          overflow;
  logic          missed;

  tick_period_meter #(
    .BW       (BW),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .tick_in      (tick_in),
    .clr_flags    (clr_flags),
    .period       (period),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .locked       (locked),
    .overflow     (overflow),
    .missed       (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: timestamps of events rather than a cycle counter.
  int            cyc = 0;
  bit            m_active = 0;
  bit            m_have_ref = 0;
  int            m_last_evt = 0;
  int            since_clear = 0;
  int            hist[$];
  logic [BW-1:0] exp_period = '0;
  logic          exp_valid = 0;
  logic          exp_locked = 0;
  logic          exp_ovf = 0;
  logic          exp_missed = 0;

  function automatic logic [BW+3:0] dut_vec();
    return {period, period_valid, locked, overflow, missed};
  endfunction

  function automatic logic [BW+3:0] exp_vec();
    return {exp_period, exp_valid, exp_locked, exp_ovf, exp_missed};
  endfunction

  function automatic bit tail_all_equal();
    if (hist.size() != LOCK_CNT + 1) return 0;
    foreach (hist[i]) if (hist[i] != hist[0]) return 0;
    return 1;
  endfunction

  task automatic step(input bit en, input bit tk, input bit rdy, input bit clr);
    bit meas;
    bit ovf;
    int el;
    int mval;
    enable       = en;
    tick_in      = tk;
    period_ready = rdy;
    clr_flags    = clr;
    @(posedge clk);
    cyc++;
    meas = 0;
    ovf  = 0;
    mval = 0;
    if (!en) begin
      m_active    = 0;
      m_have_ref  = 0;
      since_clear = 0;
    end else if (!m_active) begin
      m_active = 1;
    end else if (!m_have_ref) begin
      if (tk) begin
        m_have_ref = 1;
        m_last_evt = cyc;
      end
    end else begin
      el = cyc - m_last_evt;
      if (tk) begin
        meas       = 1;
        mval       = el;
        m_last_evt = cyc;
      end else if (el == MaxCnt) begin
        ovf         = 1;
        m_have_ref  = 0;
        since_clear = 0;
      end
    end
    exp_ovf    = (exp_ovf && !clr) || ovf;
    exp_missed = exp_missed && !clr;
    if (meas) begin
      if (!exp_valid || rdy) begin
        exp_period = mval[BW-1:0];
        exp_valid  = 1;
      end else begin
        exp_missed = 1;
      end
      hist.push_back(mval);
      if (hist.size() > LOCK_CNT + 1) void'(hist.pop_front());
      since_clear++;
    end else if (exp_valid && rdy) begin
      exp_valid = 0;
    end
    if (!en || ovf) exp_locked = 0;
    else if (meas) exp_locked = (since_clear >= LOCK_CNT) && tail_all_equal();
    #1;
  endtask

  task automatic quiesce();
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
  endtask

  task automatic test_reset();
    rst_n = 0;
    enable = 0; tick_in = 0; clr_flags = 0; period_ready = 0;
    #12;
    n_checks++;
    if (dut_vec() !== '0) $display("FAIL reset_state: dut %h want 0", dut_vec());
    else n_pass++;
    rst_n = 1;
    // Enable is low: the meter must ignore strobes and stay quiet.
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0);
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL reset_idle cyc %0d: dut %h model %h", cyc, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_divider_n2();
    int s;
    quiesce();
    step(1, 0, 1, 0);
    s = 0;
    for (int k = 0; k < 12; k++) begin
      step(1, (k % 2) == 0, 1, 0);
      if ((k % 2) == 0) s++;
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL n2 cyc %0d: dut %h model %h", cyc, dut_vec(), exp_vec());
      else n_pass++;
      if ((k % 2) == 0 && s == 2) begin
        n_checks++;
        if (period !== 8'd2 || period_valid !== 1'b1) $display("FAIL n2_first_result: period=%0d valid=%b want 2/1", period, period_valid);
        else n_pass++;
      end
      if ((k % 2) == 0 && (s == 5 || s == 6)) begin
        n_checks++;
        if (locked !== (s == 6)) $display("FAIL n2_lock strobe %0d: locked=%b want %b", s, locked, s == 6);
        else n_pass++;
      end
    end
    n_checks++;
    if (overflow !== 1'b0 || missed !== 1'b0) $display("FAIL n2_flags: ovf=%b missed=%b want 0/0", overflow, missed);
    else n_pass++;
  endtask

  task automatic test_lock_change();
    int gap;
    quiesce();
    for (int i = 0; i <= 10; i++) begin
      gap = (i < 6) ? 5 : 7;
      for (int c = 1; c <= gap; c++) begin
        step(1, c == gap, 1, 0);
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL lock_change cyc %0d: dut %h model %h", cyc, dut_vec(), exp_vec());
        else n_pass++;
      end
      if (i == 5 || i == 6 || i == 9 || i == 10) begin
        n_checks++;
        if (locked !== (i == 5 || i == 10)) $display("FAIL lock_change_locked strobe %0d: locked=%b want %b", i, locked, i == 5 || i == 10);
        else n_pass++;
      end
    end
    n_checks++;
    if (period !== 8'd7) $display("FAIL lock_change_period: period=%0d want 7", period);
    else n_pass++;
  endtask

  task automatic test_overflow();
    quiesce();
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    for (int k = 1; k <= MaxCnt; k++) begin
      step(1, 0, 1, 0);
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL overflow cyc %0d: dut %h model %h", cyc, dut_vec(), exp_vec());
      else n_pass++;
      if (k >= MaxCnt - 1) begin
        n_checks++;
        if (overflow !== (k == MaxCnt)) $display("FAIL overflow_flag k=%0d: ovf=%b want %b", k, overflow, k == MaxCnt);
        else n_pass++;
      end
    end
    // Arm again while clearing the flag, then strobe at exactly the limit.
    step(1, 1, 1, 1);
    for (int k = 1; k <= MaxCnt; k++) begin
      step(1, k == MaxCnt, 1, 0);
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL max_period cyc %0d: dut %h model %h", cyc, dut_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (period !== 8'd255 || period_valid !== 1'b1 || overflow !== 1'b0)
      $display("FAIL max_period_result: period=%0d valid=%b ovf=%b want 255/1/0", period, period_valid, overflow);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int gap;
    quiesce();
    step(1, 0, 0, 0);
    for (int i = 0; i <= 3; i++) begin
      gap = (i < 3) ? 3 : 4;
      for (int c = 1; c <= gap; c++) begin
        step(1, c == gap, (i == 3) && (c == gap), (i == 3) && (c == gap));
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL backpressure cyc %0d: dut %h model %h", cyc, dut_vec(), exp_vec());
        else n_pass++;
      end
      if (i == 2) begin
        n_checks++;
        if (period !== 8'd3 || period_valid !== 1'b1 || missed !== 1'b1)
          $display("FAIL backpressure_hold: period=%0d valid=%b missed=%b want 3/1/1", period, period_valid, missed);
        else n_pass++;
      end
    end
    n_checks++;
    if (period !== 8'd4 || period_valid !== 1'b1 || missed !== 1'b0)
      $display("FAIL backpressure_reload: period=%0d valid=%b missed=%b want 4/1/0", period, period_valid, missed);
    else n_pass++;
  endtask

  task automatic test_continuous();
    quiesce();
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    for (int r = 1; r <= 8; r++) begin
      step(1, 1, 1, 0);
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL continuous cyc %0d: dut %h model %h", cyc, dut_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      if (period !== 8'd1 || period_valid !== 1'b1 || locked !== (r >= 5))
        $display("FAIL continuous_result %0d: period=%0d valid=%b locked=%b want 1/1/%b", r, period, period_valid, locked, r >= 5);
      else n_pass++;
    end
  endtask

  task automatic test_disable();
    quiesce();
    step(1, 0, 1, 0);
    for (int i = 0; i <= 6; i++) begin
      for (int c = 1; c <= 3; c++) begin
        step(1, c == 3, i < 6, 0);
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL disable_run cyc %0d: dut %h model %h", cyc, dut_vec(), exp_vec());
        else n_pass++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0);
      n_checks++;
      if (locked !== 1'b0 || period_valid !== 1'b1 || period !== 8'd3)
        $display("FAIL disable_hold k=%0d: locked=%b valid=%b period=%0d want 0/1/3", k, locked, period_valid, period);
      else n_pass++;
    end
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    for (int c = 0; c <= 3; c++) begin
      step(1, (c == 0) || (c == 3), 1, 0);
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL reenable cyc %0d: dut %h model %h", cyc, dut_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      if (period_valid !== (c == 3)) $display("FAIL reenable_valid c=%0d: valid=%b want %b", c, period_valid, c == 3);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int gap;
    int cd;
    bit en;
    bit tk;
    gap = 3;
    cd  = 3;
    for (int k = 0; k < 6000; k++) begin
      en = ($urandom_range(0, 499) != 0);
      tk = 0;
      cd--;
      if (cd <= 0) begin
        tk = 1;
        if ($urandom_range(0, 9) < 2) begin
          if ($urandom_range(0, 9) < 2) gap = $urandom_range(MaxCnt - 2, MaxCnt + 3);
          else gap = $urandom_range(1, 8);
        end
        cd = gap;
      end
      step(en, tk, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL random cyc %0d: dut %h model %h", cyc, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_divider_n2();
    test_lock_change();
    test_overflow();
    test_backpressure();
    test_continuous();
    test_disable();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
